// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROL/ROR on a WIDTH-bit operand, with the
// log2(WIDTH) mux levels split across STAGES registered stages behind valid/ready.
module pipe_shifter #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAGW   = 5,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data,
   input  logic [SHW-1:0]   shift,
   input  logic [2:0]       op,
   input  logic [TAGW-1:0]  tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [TAGW-1:0]  tag_out
);

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   // Index of the first mux level owned by stage s; the first SHW mod STAGES
   // stages each take one extra level. level_first(STAGES) == SHW.
   function automatic int level_first(input int s);
      int base;
      int extra;
      base  = SHW / STAGES;
      extra = SHW % STAGES;
      return s * base + ((s < extra) ? s : extra);
   endfunction

   // Applies mux levels [first, last) to x. Level j shifts by 2^(SHW-1-j) and is
   // selected by shift bit SHW-1-j. SRA refills from the original sign bit.
   function automatic logic [WIDTH-1:0] shift_levels(
      input logic [WIDTH-1:0] x,
      input logic [SHW-1:0]   sh,
      input logic [2:0]       kind,
      input logic             sign,
      input int               first,
      input int               last
   );
      logic [WIDTH-1:0] acc;
      logic [SHW-1:0]   sel;
      int               amt;
      acc = x;
      for (int j = 0; j < SHW; j++) begin
         amt = 1 << (SHW - 1 - j);
         sel = sh >> (SHW - 1 - j);
         if (j >= first && j < last && sel[0]) begin
            case (kind)
               OP_SLL:  acc = acc << amt;
               OP_SRL:  acc = acc >> amt;
               OP_SRA:  acc = (acc >> amt) | ({WIDTH{sign}} << (WIDTH - amt));
               OP_ROL:  acc = (acc << amt) | (acc >> (WIDTH - amt));
               OP_ROR:  acc = (acc >> amt) | (acc << (WIDTH - amt));
               default: acc = acc;
            endcase
         end
      end
      return acc;
   endfunction

   logic             valid_q [STAGES];
   logic             valid_d [STAGES];
   logic [WIDTH-1:0] data_q  [STAGES];
   logic [WIDTH-1:0] data_d  [STAGES];
   logic [SHW-1:0]   shift_q [STAGES];
   logic [SHW-1:0]   shift_d [STAGES];
   logic [2:0]       op_q    [STAGES];
   logic [2:0]       op_d    [STAGES];
   logic             sign_q  [STAGES];
   logic             sign_d  [STAGES];
   logic [TAGW-1:0]  tag_q   [STAGES];
   logic [TAGW-1:0]  tag_d   [STAGES];

   logic [STAGES:0]  ready_c;
   logic             in_ready_c;

   // Ready ripples back from the consumer; each stage then either loads from
   // its upstream neighbour (possibly a bubble), holds, or is cleared by flush.
   always_comb begin
      logic             src_valid;
      logic [WIDTH-1:0] src_data;
      logic [SHW-1:0]   src_shift;
      logic [2:0]       src_op;
      logic             src_sign;
      logic [TAGW-1:0]  src_tag;

      ready_c[STAGES] = out_ready;
      for (int s = STAGES - 1; s >= 0; s--) begin
         ready_c[s] = !valid_q[s] || ready_c[s + 1];
      end
      in_ready_c = ready_c[0] && !flush;

      valid_d = valid_q;
      data_d  = data_q;
      shift_d = shift_q;
      op_d    = op_q;
      sign_d  = sign_q;
      tag_d   = tag_q;

      for (int s = 0; s < STAGES; s++) begin
         if (s == 0) begin
            src_valid = in_valid && in_ready_c;
            src_data  = data;
            src_shift = shift;
            src_op    = op;
            src_sign  = data[WIDTH-1];
            src_tag   = tag_in;
         end else begin
            src_valid = valid_q[s - 1];
            src_data  = data_q[s - 1];
            src_shift = shift_q[s - 1];
            src_op    = op_q[s - 1];
            src_sign  = sign_q[s - 1];
            src_tag   = tag_q[s - 1];
         end

         if (flush) begin
            valid_d[s] = 1'b0;
         end else if (ready_c[s]) begin
            valid_d[s] = src_valid;
            if (src_valid) begin
               data_d[s]  = shift_levels(src_data, src_shift, src_op, src_sign,
                                         level_first(s), level_first(s + 1));
               shift_d[s] = src_shift;
               op_d[s]    = src_op;
               sign_d[s]  = src_sign;
               tag_d[s]   = src_tag;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < STAGES; s++) begin
            valid_q[s] <= 1'b0;
            data_q[s]  <= '0;
            shift_q[s] <= '0;
            op_q[s]    <= '0;
            sign_q[s]  <= 1'b0;
            tag_q[s]   <= '0;
         end
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         shift_q <= shift_d;
         op_q    <= op_d;
         sign_q  <= sign_d;
         tag_q   <= tag_d;
      end
   end

   // zero is qualified by out_valid so that it reads 0 straight out of reset.
   assign in_ready  = in_ready_c;
   assign out_valid = valid_q[STAGES-1];
   assign result    = data_q[STAGES-1];
   assign tag_out   = tag_q[STAGES-1];
   assign zero      = valid_q[STAGES-1] && (data_q[STAGES-1] == '0);

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed self-checking bench for pipe_shifter (WIDTH=32, STAGES=2, TAGW=5).
module tb_pipe_shifter;

   localparam int WIDTH  = 32;
   localparam int STAGES = 2;
   localparam int TAGW   = 5;

   localparam logic [2:0] SLL = 3'b000;
   localparam logic [2:0] SRL = 3'b001;
   localparam logic [2:0] SRA = 3'b010;
   localparam logic [2:0] ROL = 3'b011;
   localparam logic [2:0] ROR = 3'b100;
   localparam logic [2:0] RSV = 3'b111;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  data;
   logic [4:0]        shift;
   logic [2:0]        op;
   logic [TAGW-1:0]   tag_in;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  result;
   logic              zero;
   logic [TAGW-1:0]   tag_out;

   int compared   = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   pipe_shifter #(.WIDTH(WIDTH), .STAGES(STAGES), .TAGW(TAGW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data      (data),
      .shift     (shift),
      .op        (op),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .tag_out   (tag_out)
   );

   // One comparison: counts it, and on a difference counts and reports it.
   task automatic checkOutput(input string name, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
      end
   endtask

   // Full check of a presented result: valid, value, zero flag and tag.
   task automatic checkResult(input string name, input logic [31:0] expResult,
                              input logic expZero, input logic [TAGW-1:0] expTag);
      checkOutput({name, ".valid"},  32'(out_valid), 32'd1);
      checkOutput({name, ".result"}, result,         expResult);
      checkOutput({name, ".zero"},   32'(zero),      32'(expZero));
      checkOutput({name, ".tag"},    32'(tag_out),   32'(expTag));
   endtask

   // Drives one input vector and lets combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] d,
                                input logic [4:0] sh, input logic [TAGW-1:0] t);
      in_valid = v;
      op       = o;
      data     = d;
      shift    = sh;
      tag_in   = t;
      #1;
   endtask

   task automatic tick;
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      applyStimulus(1'b0, SLL, 32'h0, 5'd0, 5'd0);

      // Reset state
      @(negedge clock);
      #1;
      checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
      checkOutput("reset.result",    result,         32'h0);
      checkOutput("reset.zero",      32'(zero),      32'd0);
      checkOutput("reset.tag",       32'(tag_out),   32'd0);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      tick();

      // Back-to-back shifts, two-cycle latency
      applyStimulus(1'b1, SRA, 32'h80000000, 5'd4, 5'd1);
      tick();
      checkOutput("lat.first_not_yet", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, SRL, 32'h80000000, 5'd31, 5'd2);
      tick();
      checkResult("sra4", 32'hF8000000, 1'b0, 5'd1);
      applyStimulus(1'b1, SLL, 32'h00000001, 5'd31, 5'd3);
      tick();
      checkResult("srl31", 32'h00000001, 1'b0, 5'd2);
      applyStimulus(1'b0, SLL, 32'h0, 5'd0, 5'd0);
      tick();
      checkResult("sll31", 32'h80000000, 1'b0, 5'd3);
      tick();
      checkOutput("drain.out_valid", 32'(out_valid), 32'd0);

      // Rotates, reserved op, zero flag, sign fill corners
      applyStimulus(1'b1, ROL, 32'h80000001, 5'd1, 5'd4);
      tick();
      applyStimulus(1'b1, ROR, 32'h00000003, 5'd1, 5'd5);
      tick();
      checkResult("rol1", 32'h00000003, 1'b0, 5'd4);
      applyStimulus(1'b1, ROR, 32'h12345678, 5'd0, 5'd6);
      tick();
      checkResult("ror1", 32'h80000001, 1'b0, 5'd5);
      applyStimulus(1'b1, RSV, 32'hDEADBEEF, 5'd7, 5'd7);
      tick();
      checkResult("ror0", 32'h12345678, 1'b0, 5'd6);
      applyStimulus(1'b1, SRA, 32'h80000000, 5'd31, 5'd8);
      tick();
      checkResult("reserved", 32'hDEADBEEF, 1'b0, 5'd7);
      applyStimulus(1'b1, SRL, 32'h0000000F, 5'd4, 5'd9);
      tick();
      checkResult("sra31", 32'hFFFFFFFF, 1'b0, 5'd8);
      applyStimulus(1'b1, SLL, 32'hFFFFFFFF, 5'd0, 5'd10);
      tick();
      checkResult("zero_flag", 32'h00000000, 1'b1, 5'd9);
      applyStimulus(1'b1, SRA, 32'h7FFFFFF0, 5'd4, 5'd11);
      tick();
      checkResult("sll0", 32'hFFFFFFFF, 1'b0, 5'd10);
      applyStimulus(1'b1, ROL, 32'h00000001, 5'd31, 5'd12);
      tick();
      checkResult("sra_pos", 32'h07FFFFFF, 1'b0, 5'd11);
      applyStimulus(1'b0, SLL, 32'h0, 5'd0, 5'd0);
      tick();
      checkResult("rol31", 32'h80000000, 1'b0, 5'd12);
      tick();

      // Back-pressure: pipeline fills after two, output holds, FIFO drain
      out_ready = 1'b0;
      applyStimulus(1'b1, SLL, 32'h1, 5'd4, 5'd1);
      checkOutput("bp.in_ready0", 32'(in_ready), 32'd1);
      tick();
      applyStimulus(1'b1, SLL, 32'h2, 5'd4, 5'd2);
      checkOutput("bp.in_ready1", 32'(in_ready), 32'd1);
      tick();
      applyStimulus(1'b1, SLL, 32'h3, 5'd4, 5'd3);
      checkOutput("bp.in_ready_full", 32'(in_ready), 32'd0);
      checkResult("bp.hold_a", 32'h10, 1'b0, 5'd1);
      tick();
      checkResult("bp.hold_b", 32'h10, 1'b0, 5'd1);
      checkOutput("bp.in_ready_still", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1;
      checkOutput("bp.in_ready_release", 32'(in_ready), 32'd1);
      tick();
      checkResult("bp.tag2", 32'h20, 1'b0, 5'd2);
      applyStimulus(1'b1, SLL, 32'h4, 5'd4, 5'd4);
      tick();
      checkResult("bp.tag3", 32'h30, 1'b0, 5'd3);
      applyStimulus(1'b0, SLL, 32'h0, 5'd0, 5'd0);
      tick();
      checkResult("bp.tag4", 32'h40, 1'b0, 5'd4);
      tick();
      checkOutput("bp.drained", 32'(out_valid), 32'd0);

      // Flush with two in flight and a new op presented
      out_ready = 1'b0;
      applyStimulus(1'b1, SLL, 32'h5, 5'd0, 5'd5);
      tick();
      applyStimulus(1'b1, SLL, 32'h6, 5'd0, 5'd6);
      tick();
      applyStimulus(1'b1, SLL, 32'h7, 5'd0, 5'd7);
      flush = 1'b1;
      #1;
      checkOutput("flush.in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      applyStimulus(1'b0, SLL, 32'h0, 5'd0, 5'd0);
      checkOutput("flush.out_valid", 32'(out_valid), 32'd0);
      checkOutput("flush.in_ready_after", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      applyStimulus(1'b1, SRL, 32'h00000100, 5'd8, 5'd8);
      tick();
      checkOutput("flush.dropped_op", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, SLL, 32'h0, 5'd0, 5'd0);
      tick();
      checkResult("flush.next", 32'h00000001, 1'b0, 5'd8);
      tick();

      // Asynchronous reset between edges with the pipeline full
      out_ready = 1'b0;
      applyStimulus(1'b1, ROL, 32'h000000A5, 5'd4, 5'd9);
      tick();
      applyStimulus(1'b1, SLL, 32'h00000003, 5'd1, 5'd10);
      tick();
      applyStimulus(1'b0, SLL, 32'h0, 5'd0, 5'd0);
      checkResult("rst.pre", 32'h00000A50, 1'b0, 5'd9);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst.result",    result,         32'h0);
      checkOutput("rst.tag",       32'(tag_out),   32'd0);
      checkOutput("rst.zero",      32'(zero),      32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      applyStimulus(1'b1, SLL, 32'h00000003, 5'd2, 5'd11);
      tick();
      applyStimulus(1'b0, SLL, 32'h0, 5'd0, 5'd0);
      tick();
      checkResult("rst.fresh", 32'h0000000C, 1'b0, 5'd11);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
